serial_subtractor: RTL and testbench

Bit-serial N-bit unsigned subtractor that computes `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell and a borrow flip-flop carried between cycles. It sits directly downstream of the full-subtractor cell and consumes its diff/borrow outputs every cycle. Upstream logic sees a start/busy/done handshake with registered results.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: i_a - i_b - i_bin.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);

  logic w_axb;

  // Difference and borrow-out for one bit position.
  always_comb begin
    w_axb  = i_a ^ i_b;
    o_diff = w_axb ^ i_bin;
    o_bout = (~i_a & i_b) | (~w_axb & i_bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic [WIDTH-1:0] w_diff_shift;
  logic [CntW-1:0]  r_cnt;
  logic             r_brw;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_cell (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_brw),
    .o_diff (w_d),
    .o_bout (w_bo)
  );

  // State register; reset wins over a simultaneous start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; start is only honoured outside SHIFT.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = (r_state == StShift) && (r_cnt == CntW'(WIDTH - 1));
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StShift;
          w_accept     = 1'b1;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (i_start) begin
          w_state_next = StShift;
          w_accept     = 1'b1;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // New difference bit enters at the MSB so bit 0 ends at the LSB after WIDTH shifts.
  always_comb begin
    w_diff_shift = (r_diff_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  end

  // Datapath: operand capture, serial shifting and result registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_cnt     <= '0;
      r_brw     <= 1'b0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
    end else if (w_accept) begin
      r_a_sr    <= i_a;
      r_b_sr    <= i_b;
      r_diff_sr <= '0;
      r_cnt     <= '0;
      r_brw     <= 1'b0;
    end else if (r_state == StShift) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_diff_sr <= w_diff_shift;
      r_brw     <= w_bo;
      r_cnt     <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_diff_shift;
        r_bout <= w_bo;
      end
    end
  end

  assign o_busy = (r_state == StShift);
  assign o_done = (r_state == StDone);
  assign o_diff = r_diff;
  assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_diff;
  logic       o_bout;

  int n_checks;
  int n_pass;

  // Model of the held result registers.
  logic [7:0] m_diff;
  logic       m_bout;

  serial_subtractor #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_diff  (o_diff),
    .o_bout  (o_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_op(input logic [7:0] a, input logic [7:0] b);
    int unsigned d;
    d      = (int'(a) - int'(b) + 256) % 256;
    m_diff = d[7:0];
    m_bout = (a < b);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // One full operation from IDLE/DONE; optional stray start mid-SHIFT.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit ign);
    int cyc;
    i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_val("accept_busy", {31'd0, o_busy}, 32'd1);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 20) begin
      check_val("shift_hold", {23'd0, o_bout, o_diff}, {23'd0, m_bout, m_diff});
      if (ign && cyc == 2) begin
        i_start = 1'b1; i_a = ~a; i_b = a ^ 8'h5c;
      end else begin
        i_start = 1'b0;
      end
      tick();
      cyc++;
    end
    i_start = 1'b0;
    check_val("latency", cyc, 32'd8);
    model_op(a, b);
    check_val("diff", {24'd0, o_diff}, {24'd0, m_diff});
    check_val("bout", {31'd0, o_bout}, {31'd0, m_bout});
    check_val("busy_at_done", {31'd0, o_busy}, 32'd0);
    tick();
    check_val("done_pulse_end", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int n1;
    int n2;
    n_checks = 0; n_pass = 0;
    m_diff = 8'h00; m_bout = 1'b0;
    i_rst_n = 1'b0; i_start = 1'b0; i_a = 8'h00; i_b = 8'h00;
    tick(); tick();
    i_rst_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("idle", {21'd0, o_busy, o_done, o_bout, o_diff}, 32'd0);
    end

    // Directed operations.
    run_op(8'h5A, 8'h23, 1'b0);
    check_val("dir_5a_23", {23'd0, o_bout, o_diff}, {23'd0, 1'b0, 8'h37});
    run_op(8'h10, 8'h20, 1'b0);
    check_val("dir_10_20", {23'd0, o_bout, o_diff}, {23'd0, 1'b1, 8'hF0});
    run_op(8'hFF, 8'hFF, 1'b0);
    check_val("dir_ff_ff", {23'd0, o_bout, o_diff}, {23'd0, 1'b0, 8'h00});

    // Back-to-back with start held high.
    i_a = 8'h01; i_b = 8'h02; i_start = 1'b1;
    tick();
    check_val("b2b_busy1", {31'd0, o_busy}, 32'd1);
    wait_done(n1);
    check_val("b2b_lat1", n1, 32'd8);
    check_val("b2b_res1", {23'd0, o_bout, o_diff}, {23'd0, 1'b1, 8'hFF});
    i_a = 8'h80; i_b = 8'h01;
    tick();
    check_val("b2b_no_gap", {30'd0, o_busy, o_done}, 32'd2);
    wait_done(n2);
    check_val("b2b_pulse_gap", n2 + 1, 32'd9);
    check_val("b2b_res2", {23'd0, o_bout, o_diff}, {23'd0, 1'b0, 8'h7F});
    i_start = 1'b0;
    tick();
    check_val("b2b_idle", {30'd0, o_busy, o_done}, 32'd0);
    model_op(8'h80, 8'h01);

    // Stray start during SHIFT is ignored.
    run_op(8'h3C, 8'hA5, 1'b1);
    check_val("ign_res", {23'd0, o_bout, o_diff}, {23'd0, 1'b1, 8'h97});

    // Reset mid-operation aborts.
    i_a = 8'hC3; i_b = 8'h3C; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b0;
    tick();
    check_val("rst_abort", {21'd0, o_busy, o_done, o_bout, o_diff}, 32'd0);
    m_diff = 8'h00; m_bout = 1'b0;
    i_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("rst_no_rearm", {30'd0, o_busy, o_done}, 32'd0);
    end
    run_op(8'hC3, 8'h3C, 1'b0);

    // Reset wins over a simultaneous start.
    i_rst_n = 1'b0; i_start = 1'b1;
    tick();
    check_val("rst_vs_start", {21'd0, o_busy, o_done, o_bout, o_diff}, 32'd0);
    m_diff = 8'h00; m_bout = 1'b0;
    i_rst_n = 1'b1; i_start = 1'b0;
    tick();
    check_val("rst_vs_start_after", {31'd0, o_busy}, 32'd0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
